// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types, opcodes and saturation helpers for addsub_serial.
//   state_t        : FSM state encoding (IDLE, RUN, DONE)
//   OP_ADD/OP_SUB  : encodings of the mode input
//   sat_max/sat_min: signed extremes for a given width, returned in the low
//                    w bits of a SAT_W-bit word (w must be <= SAT_W)
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int SAT_W = 64;

  // Largest positive two's complement value: 0 followed by w-1 ones.
  function automatic logic [SAT_W-1:0] sat_max(input int w);
    logic [SAT_W-1:0] one;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    return (one << (w - 1)) - one;
  endfunction

  // Most negative two's complement value: 1 followed by w-1 zeros.
  function automatic logic [SAT_W-1:0] sat_min(input int w);
    logic [SAT_W-1:0] one;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    return one << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit ripple-carry adder slice.
//   x, y : operand slices
//   cin  : carry in
//   s    : sum slice
//   cout : carry out of the top bit
//   cmsb : carry into the top bit (used to derive signed overflow)
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic cy;

  always_comb begin
    cy   = cin;
    s    = '0;
    cmsb = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) cmsb = cy;
      s[i] = x[i] ^ y[i] ^ cy;
      cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    cout = cy;
  end

endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle add/subtract, CHUNK bits per clock, LSB first.
//   clk, rst    : clock, synchronous active-high reset
//   start       : request, taken only in IDLE (a, b, mode, sat captured then)
//   a, b        : operands; mode 0 = a+b, 1 = a-b; sat clamps signed overflow
//   busy        : high while chunks are being processed
//   done        : one-cycle pulse when result and flags update
//   result      : registered result, held until the next done
//   c, v, z     : carry out (1 = no borrow on subtract), signed overflow
//                 (pre-saturation), final result == 0
//   dbg_state   : current FSM state
//
// Handshake: a request is a cycle with start=1 while the FSM is IDLE; it is
// accepted on that edge. Requests in any other state are dropped, never
// queued. Exactly one done pulse follows each accepted request unless rst
// intervenes; the done cycle is already IDLE, so a start there is accepted.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             v,
  output logic             z,
  output state_t           dbg_state
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [SAT_W-1:0] SMAX_FULL = sat_max(WIDTH);
  localparam logic [SAT_W-1:0] SMIN_FULL = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] SMAX      = SMAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMIN      = SMIN_FULL[WIDTH-1:0];

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("addsub_serial: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             carry_q,  carry_d;
  logic             cm_q,     cm_d;
  logic             sat_q,    sat_d;
  logic             amsb_q,   amsb_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_q,      c_d;
  logic             v_q,      v_d;
  logic             z_q,      z_d;
  logic             done_q,   done_d;
  logic             busy_q,   busy_d;

  logic [CHUNK-1:0] ch_s;
  logic             ch_cout;
  logic             ch_cmsb;

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (a_q[CHUNK-1:0]),
    .y    (b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .s    (ch_s),
    .cout (ch_cout),
    .cmsb (ch_cmsb)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cm_d     = cm_q;
    sat_d    = sat_q;
    amsb_d   = amsb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    c_d      = c_q;
    v_d      = v_q;
    z_d      = z_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry.
          a_d     = a;
          b_d     = b ^ {WIDTH{mode}};
          carry_d = (mode == OP_SUB);
          sat_d   = sat;
          amsb_d  = a[WIDTH-1];
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // New chunk enters at the top; after NCH shifts chunk 0 sits at the LSB.
        sum_d                    = sum_q >> CHUNK;
        sum_d[WIDTH-1 -: CHUNK]  = ch_s;
        a_d                      = a_q >> CHUNK;
        b_d                      = b_q >> CHUNK;
        carry_d                  = ch_cout;
        // Overwritten every chunk; the last one is the carry into the word MSB.
        cm_d                     = ch_cmsb;
        cnt_d                    = cnt_q + CW'(1);
        if (cnt_q == CW'(NCH - 1)) state_d = DONE;
      end
      DONE: begin
        c_d = carry_q;
        v_d = cm_q ^ carry_q;
        // On overflow the true result has the sign of a, so clamp toward it.
        if (sat_q && (cm_q ^ carry_q)) result_d = amsb_q ? SMIN : SMAX;
        else                           result_d = sum_q;
        z_d     = (result_d == '0);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cm_q     <= 1'b0;
      sat_q    <= 1'b0;
      amsb_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cm_q     <= cm_d;
      sat_q    <= sat_d;
      amsb_q   <= amsb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      c_q      <= c_d;
      v_q      <= v_d;
      z_q      <= z_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign c         = c_q;
  assign v         = v_q;
  assign z         = z_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed-vector bench for addsub_serial (WIDTH=16, CHUNK=4).
module tb_addsub_serial;
  import addsub_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         mode = 1'b0;
  logic         sat = 1'b0;
  logic         busy, done, c, v, z;
  logic [W-1:0] result;
  state_t       dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  addsub_serial #(.WIDTH(W), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .mode(mode), .sat(sat),
    .busy(busy), .done(done), .result(result), .c(c), .v(v), .z(z),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Present a request at a negedge, let edge 0 take it, then scramble the
  // inputs (they must not matter after the start cycle). lat is the number
  // of edges after edge 0 at which done is seen (-1 if never); bcnt counts
  // negedges with busy high.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic imode, input logic isat,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; mode = imode; sat = isat;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom_range(0, 65535));
    b = W'($urandom_range(0, 65535));
    mode = 1'($urandom_range(0, 1));
    sat = 1'($urandom_range(0, 1));
    lat = -1;
    bcnt = 0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
    n_vec++; if (result !== 16'h0000) begin n_bad++; $display("FAIL reset_result got %h exp 0000", result); end
    n_vec++; if ({c, v, z} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got cvz=%b exp 000", {c, v, z}); end
    n_vec++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat, bc;
    run_op(16'h1234, 16'h0101, 1'b0, 1'b0, lat, bc);
    n_vec++; if (lat !== 5) begin n_bad++; $display("FAIL add_latency got %0d exp 5", lat); end
    n_vec++; if (bc !== 4) begin n_bad++; $display("FAIL add_busy_cycles got %0d exp 4", bc); end
    n_vec++; if (result !== 16'h1335) begin n_bad++; $display("FAIL add_result got %h exp 1335", result); end
    n_vec++; if ({c, v, z} !== 3'b000) begin n_bad++; $display("FAIL add_flags got cvz=%b exp 000", {c, v, z}); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL add_done_width got %b exp 0", done); end
  endtask

  task automatic test_sub();
    int lat, bc;
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, lat, bc);
    n_vec++; if (lat !== 5) begin n_bad++; $display("FAIL sub_borrow_latency got %0d exp 5", lat); end
    n_vec++; if (result !== 16'hFFFE) begin n_bad++; $display("FAIL sub_borrow_result got %h exp fffe", result); end
    n_vec++; if ({c, v, z} !== 3'b000) begin n_bad++; $display("FAIL sub_borrow_flags got cvz=%b exp 000", {c, v, z}); end
    run_op(16'h4321, 16'h4321, 1'b1, 1'b0, lat, bc);
    n_vec++; if (result !== 16'h0000) begin n_bad++; $display("FAIL sub_equal_result got %h exp 0000", result); end
    n_vec++; if ({c, v, z} !== 3'b101) begin n_bad++; $display("FAIL sub_equal_flags got cvz=%b exp 101", {c, v, z}); end
  endtask

  task automatic test_overflow();
    int lat, bc;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bc);
    n_vec++; if (result !== 16'h8000) begin n_bad++; $display("FAIL add_ovf_result got %h exp 8000", result); end
    n_vec++; if ({c, v, z} !== 3'b010) begin n_bad++; $display("FAIL add_ovf_flags got cvz=%b exp 010", {c, v, z}); end
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, lat, bc);
    n_vec++; if (result !== 16'h7FFF) begin n_bad++; $display("FAIL add_sat_result got %h exp 7fff", result); end
    n_vec++; if ({c, v, z} !== 3'b010) begin n_bad++; $display("FAIL add_sat_flags got cvz=%b exp 010", {c, v, z}); end
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, lat, bc);
    n_vec++; if (result !== 16'h7FFF) begin n_bad++; $display("FAIL sub_ovf_result got %h exp 7fff", result); end
    n_vec++; if ({c, v, z} !== 3'b110) begin n_bad++; $display("FAIL sub_ovf_flags got cvz=%b exp 110", {c, v, z}); end
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, lat, bc);
    n_vec++; if (result !== 16'h8000) begin n_bad++; $display("FAIL sub_sat_result got %h exp 8000", result); end
    n_vec++; if ({c, v, z} !== 3'b110) begin n_bad++; $display("FAIL sub_sat_flags got cvz=%b exp 110", {c, v, z}); end
  endtask

  task automatic test_ignore_busy();
    int lat, extra;
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h0101; mode = 1'b0; sat = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin start = 1'b1; a = 16'hAAAA; b = 16'h5555; mode = 1'b1; end
      if (i == 2) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    n_vec++; if (lat !== 5) begin n_bad++; $display("FAIL ignore_latency got %0d exp 5", lat); end
    n_vec++; if (result !== 16'h1335) begin n_bad++; $display("FAIL ignore_result got %h exp 1335", result); end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_vec++; if (extra !== 0) begin n_bad++; $display("FAIL ignore_extra_done got %0d exp 0", extra); end
    n_vec++; if (result !== 16'h1335) begin n_bad++; $display("FAIL ignore_result_held got %h exp 1335", result); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    @(negedge clk);
    start = 1'b1; a = 16'h1000; b = 16'h0234; mode = 1'b0; sat = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat1 = -1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat1 = i;
        break;
      end
    end
    n_vec++; if (lat1 !== 5) begin n_bad++; $display("FAIL b2b_first_latency got %0d exp 5", lat1); end
    n_vec++; if (result !== 16'h1234) begin n_bad++; $display("FAIL b2b_first_result got %h exp 1234", result); end
    // Still in the done cycle: request the second operation now.
    start = 1'b1; a = 16'h0003; b = 16'h0001; mode = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat2 = -1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) begin
        n_vec++; if (result !== 16'h1234) begin n_bad++; $display("FAIL b2b_result_hold got %h exp 1234", result); end
      end
      if (done) begin
        lat2 = i;
        break;
      end
    end
    n_vec++; if (lat2 !== 5) begin n_bad++; $display("FAIL b2b_second_latency got %0d exp 5", lat2); end
    n_vec++; if (result !== 16'h0002) begin n_bad++; $display("FAIL b2b_second_result got %h exp 0002", result); end
    n_vec++; if ({c, v, z} !== 3'b100) begin n_bad++; $display("FAIL b2b_second_flags got cvz=%b exp 100", {c, v, z}); end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, dn;
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h0101; mode = 1'b0; sat = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);   // RUN cycle 1
    @(negedge clk);   // RUN cycle 2
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_run_busy got %b exp 0", busy); end
    n_vec++; if (result !== 16'h0000) begin n_bad++; $display("FAIL rst_run_result got %h exp 0000", result); end
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dn++;
    end
    n_vec++; if (dn !== 0) begin n_bad++; $display("FAIL rst_run_no_done got %0d exp 0", dn); end
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bc);
    n_vec++; if (lat !== 5) begin n_bad++; $display("FAIL rst_fresh_latency got %0d exp 5", lat); end
    n_vec++; if (result !== 16'h0000) begin n_bad++; $display("FAIL rst_fresh_result got %h exp 0000", result); end
    n_vec++; if ({c, v, z} !== 3'b101) begin n_bad++; $display("FAIL rst_fresh_flags got cvz=%b exp 101", {c, v, z}); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
